// File: rtl/vicii_sprite_priority_pkg.sv
// vicii_sprite_priority_pkg: shared VIC-II constants for the sprite priority/collision block.
package vicii_sprite_priority_pkg;
    localparam int COLOR_W = 4;
    localparam logic [5:0] ADDR_MM = 6'h1E;
    localparam logic [5:0] ADDR_MD = 6'h1F;
endpackage

// File: rtl/vicii_sprite_priority_prio_enc.sv
// vicii_prio_enc: lowest-index-wins priority encoder over the sprite enables.
module vicii_prio_enc #(
    parameter int NSPR = 8
) (
    input  logic [NSPR-1:0]         en,
    output logic [$clog2(NSPR)-1:0] idx,
    output logic                    valid
);
    always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (en[i]) begin
                idx = ($clog2(NSPR))'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vicii_sprite_priority.sv
// vicii_sprite_priority: sprite/background/border colour mux with sticky
// sprite-sprite and sprite-data collision registers and their interrupts.
module vicii_sprite_priority
    import vicii_sprite_priority_pkg::*;
#(
    parameter int NSPR = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSPR-1:0]         spr_en,
    input  logic [NSPR*COLOR_W-1:0] spr_pix,
    input  logic [NSPR-1:0]         MDP,
    input  logic [COLOR_W-1:0]      bg_pix,
    input  logic                    bg_fg,
    input  logic                    den,
    input  logic [COLOR_W-1:0]      EC,
    input  logic                    rd_mm,
    input  logic                    rd_md,
    output logic [COLOR_W-1:0]      pixel,
    output logic [NSPR-1:0]         MM,
    output logic [NSPR-1:0]         MD,
    output logic                    irq_mm,
    output logic                    irq_md
);
    logic [$clog2(NSPR)-1:0] w;
    logic                    w_valid;
    logic [COLOR_W-1:0]      pix_nx;
    logic [NSPR-1:0]         mm_set, md_set, mm_nx, md_nx;

    vicii_prio_enc #(.NSPR(NSPR)) u_enc (
        .en(spr_en),
        .idx(w),
        .valid(w_valid)
    );

    // A hidden winner masks every lower-priority sprite: fall back to graphics.
    always_comb begin
        pix_nx = !den ? EC
               : (!w_valid || (MDP[w] && bg_fg)) ? bg_pix
               : spr_pix[w*COLOR_W +: COLOR_W];
        mm_set = ((spr_en & (spr_en - 1'b1)) != '0) ? spr_en : '0;
        md_set = bg_fg ? spr_en : '0;
        mm_nx = rd_mm ? mm_set : (MM | mm_set);
        md_nx = rd_md ? md_set : (MD | md_set);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel <= '0;
            MM <= '0;
            MD <= '0;
            irq_mm <= 1'b0;
            irq_md <= 1'b0;
        end else begin
            pixel <= pix_nx;
            MM <= mm_nx;
            MD <= md_nx;
            irq_mm <= (MM == '0) && (mm_nx != '0);
            irq_md <= (MD == '0) && (md_nx != '0);
        end
    end
endmodule
